fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline. It sits directly upstream of the instruction memory and feeds the decode stage.
- Holds the program counter and drives pc_out to the instruction memory. Captures the returned instruction, together with PC+4, into the IF/ID pipeline register.
- Applies stalls from hazard detection, and applies branch/jump redirects and flushes from later stages.
- Keeps a retired-fetch counter and a sticky misaligned-target flag.

Parameters:
- RESET_PC, 32'h0000_0004: PC value after reset. The instruction memory maps PC 4 to word 0.
- PC_STEP, 4: sequential PC increment in bytes.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID contents (load-use hazard)
- flush  in  1  discard the instruction being captured into IF/ID
- branch_taken  in  1  redirect PC to branch_target
- branch_target  in  32  byte address
- jump  in  1  redirect PC to jump_target
- jump_target  in  32  byte address
- instruction  in  32  combinational read data from instruction memory for pc_out
- pc_out  out  32  current PC, drives instruction memory address
- ifid_instr  out  32  registered instruction to decode
- ifid_pc_plus4  out  32  registered PC+4 of ifid_instr
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- fetch_count  out  32  count of valid instructions delivered to IF/ID
- misaligned  out  1  sticky: a redirect target had bits [1:0] != 0

Behaviour:
- All state updates on the rising clk edge. No asynchronous paths except pc_out, which is a register output, and instruction, which is consumed combinationally.
- Reset (sync, dominates everything):
  - pc_out = RESET_PC
  - ifid_instr = 0, ifid_pc_plus4 = 0, ifid_valid = 0
  - fetch_count = 0, misaligned = 0
- Next-PC priority, evaluated per edge with reset deasserted:
  1. jump: PC <= {jump_target[31:2], 2'b00}
  2. branch_taken: PC <= {branch_target[31:2], 2'b00}. Jump wins if both are asserted.
  3. stall: PC holds.
  4. otherwise: PC <= PC + PC_STEP, mod 2^32. 0xFFFF_FFFC wraps to 0x0000_0000.
- A redirect (jump or branch_taken) overrides stall for the PC. The stalled wrong-path fetch is dropped.
- IF/ID update, in priority order:
  - If redirect or flush: ifid_valid <= 0, ifid_instr <= 0, ifid_pc_plus4 <= 0 (bubble). This applies even when stall is asserted.
  - Else if stall: IF/ID holds all fields.
  - Else: ifid_instr <= instruction, ifid_pc_plus4 <= pc_out + PC_STEP, ifid_valid <= 1.
- flush alone does not change the PC. The PC advances or holds per the priority list above.
- fetch_count increments by 1 on each edge where IF/ID loads a valid instruction (the last IF/ID case above). It wraps from 0xFFFF_FFFF to 0. It is not incremented on stall, flush, or redirect edges.
- misaligned is set on any edge where the selected redirect target has bits [1:0] != 0. It stays set until reset. The target is still used, with bits [1:0] forced to 00.
- Latency:
  - PC to ifid_instr: 1 cycle.
  - A redirect asserted in cycle N gives pc_out = target in cycle N+1. The first valid target instruction appears in IF/ID in cycle N+2.
- Reset mid-stall or mid-redirect: reset wins and the pipeline restarts at RESET_PC with ifid_valid = 0.

Test Plan:
- Reset then run 3 cycles, memory word0 = 0xA2310011, word1 = 0xA2520003:
  - pc_out = 4, 8, 12
  - ifid_instr = 0xA2310011 then 0xA2520003
  - ifid_pc_plus4 = 8 then 12
  - fetch_count = 2
- Stall held 2 cycles with pc_out = 12: pc_out stays 12, IF/ID unchanged, fetch_count unchanged. Release: pc_out = 16 next edge.
- Redirect precedence:
  - branch_taken = 1, target = 0x28, at pc_out = 16: next pc_out = 0x28, ifid_valid = 0. The following edge loads word9 = 0x01525020 with ifid_pc_plus4 = 0x2C.
  - Same cycle with jump = 1, target = 0x14 also asserted: pc_out = 0x14.
- Stall + branch_taken in the same cycle: branch wins, pc_out = target, IF/ID bubble, fetch_count not incremented.
- Misaligned jump_target = 0x0000_0016: pc_out = 0x14, misaligned = 1 and stays 1 across later cycles until reset clears it.
- PC wrap: force PC near top via jump_target = 0xFFFF_FFFC, no stall. Next pc_out = 0x0000_0000 and ifid_pc_plus4 = 0x0000_0000.

Source files
------------

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection with redirects,
// IF/ID pipeline register, retired-fetch counter and sticky misaligned flag.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0004,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count,
  output logic        misaligned
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_seq;
  logic        load_valid;

  // Jump outranks branch when both arrive in the same cycle.
  assign redirect   = jump | branch_taken;
  assign target     = jump ? jump_target : branch_target;
  assign pc_seq     = pc_out + STEP;
  assign load_valid = !redirect && !flush && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out <= RESET_PC;
    end else if (redirect) begin
      pc_out <= {target[31:2], 2'b00};
    end else if (!stall) begin
      pc_out <= pc_seq;
    end
  end

  // Redirect/flush bubble the IF/ID register even while stalled.
  always_ff @(posedge clk) begin
    if (reset || redirect || flush) begin
      ifid_instr    <= '0;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
    end else if (!stall) begin
      ifid_instr    <= instruction;
      ifid_pc_plus4 <= pc_seq;
      ifid_valid    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      misaligned  <= 1'b0;
    end else begin
      if (load_valid)
        fetch_count <= fetch_count + 32'd1;
      if (redirect && (target[1:0] != 2'b00))
        misaligned <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small word-addressed instruction memory.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target, instruction;
  logic [31:0] pc_out, ifid_instr, ifid_pc_plus4, fetch_count;
  logic        ifid_valid, misaligned;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [16];
  logic [31:0] idx;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .instruction(instruction),
    .pc_out(pc_out), .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid), .fetch_count(fetch_count), .misaligned(misaligned)
  );

  // PC 4 maps to word 0; out-of-range addresses return a PC-derived pattern.
  always_comb begin
    idx = (pc_out - 32'd4) >> 2;
    if (idx < 32'd16) instruction = mem[idx[3:0]];
    else              instruction = 32'hFEED_0000 ^ pc_out;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 32'h1000_0000 + k;
    mem[0] = 32'hA231_0011;
    mem[1] = 32'hA252_0003;
    mem[9] = 32'h0152_5020;

    reset = 1; stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0;
    step(); step();
    chk("rst_pc", pc_out, 32'h4);
    chk("rst_valid", 32'(ifid_valid), 0);
    chk("rst_instr", ifid_instr, 0);
    chk("rst_pp4", ifid_pc_plus4, 0);
    chk("rst_cnt", fetch_count, 0);
    chk("rst_mis", 32'(misaligned), 0);

    reset = 0;
    step();
    chk("seq1_pc", pc_out, 32'h8);
    chk("seq1_instr", ifid_instr, 32'hA231_0011);
    chk("seq1_pp4", ifid_pc_plus4, 32'h8);
    chk("seq1_valid", 32'(ifid_valid), 1);
    step();
    chk("seq2_pc", pc_out, 32'hC);
    chk("seq2_instr", ifid_instr, 32'hA252_0003);
    chk("seq2_pp4", ifid_pc_plus4, 32'hC);
    chk("seq2_cnt", fetch_count, 2);

    stall = 1;
    for (int s = 0; s < 2; s++) begin
      step();
      chk("stall_pc", pc_out, 32'hC);
      chk("stall_instr", ifid_instr, 32'hA252_0003);
      chk("stall_pp4", ifid_pc_plus4, 32'hC);
      chk("stall_cnt", fetch_count, 2);
    end
    stall = 0;
    step();
    chk("unstall_pc", pc_out, 32'h10);
    chk("unstall_instr", ifid_instr, 32'h1000_0002);
    chk("unstall_cnt", fetch_count, 3);

    branch_taken = 1; branch_target = 32'h28;
    step();
    chk("br_pc", pc_out, 32'h28);
    chk("br_valid", 32'(ifid_valid), 0);
    chk("br_instr", ifid_instr, 0);
    chk("br_cnt", fetch_count, 3);
    branch_taken = 0;
    step();
    chk("br_tgt_instr", ifid_instr, 32'h0152_5020);
    chk("br_tgt_pp4", ifid_pc_plus4, 32'h2C);
    chk("br_tgt_cnt", fetch_count, 4);

    branch_taken = 1; branch_target = 32'h28; jump = 1; jump_target = 32'h14;
    step();
    chk("jmp_wins_pc", pc_out, 32'h14);
    chk("jmp_valid", 32'(ifid_valid), 0);
    branch_taken = 0; jump = 0;
    step();
    chk("jmp_next_pc", pc_out, 32'h18);
    chk("jmp_tgt_instr", ifid_instr, 32'h1000_0004);
    chk("jmp_cnt", fetch_count, 5);

    stall = 1; branch_taken = 1; branch_target = 32'h40;
    step();
    chk("stbr_pc", pc_out, 32'h40);
    chk("stbr_valid", 32'(ifid_valid), 0);
    chk("stbr_cnt", fetch_count, 5);
    chk("stbr_mis", 32'(misaligned), 0);
    stall = 0; branch_taken = 0;

    flush = 1;
    step();
    chk("fl_pc", pc_out, 32'h44);
    chk("fl_valid", 32'(ifid_valid), 0);
    chk("fl_cnt", fetch_count, 5);
    flush = 0;
    step();
    chk("fl_rel_valid", 32'(ifid_valid), 1);
    chk("fl_rel_cnt", fetch_count, 6);
    chk("fl_rel_pc", pc_out, 32'h48);
    flush = 1; stall = 1;
    step();
    chk("flst_pc", pc_out, 32'h48);
    chk("flst_valid", 32'(ifid_valid), 0);
    chk("flst_cnt", fetch_count, 6);
    flush = 0; stall = 0;

    jump = 1; jump_target = 32'h16;
    step();
    chk("mis_pc", pc_out, 32'h14);
    chk("mis_set", 32'(misaligned), 1);
    jump = 0;
    step();
    chk("mis_hold1", 32'(misaligned), 1);
    chk("mis_pc2", pc_out, 32'h18);
    step();
    chk("mis_hold2", 32'(misaligned), 1);

    jump = 1; jump_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_top_pc", pc_out, 32'hFFFF_FFFC);
    jump = 0;
    step();
    chk("wrap_pc", pc_out, 32'h0);
    chk("wrap_pp4", ifid_pc_plus4, 32'h0);
    chk("wrap_instr", ifid_instr, 32'h0112_FFFC);
    chk("wrap_valid", 32'(ifid_valid), 1);

    stall = 1; jump = 1; jump_target = 32'h80; reset = 1;
    step();
    chk("rst2_pc", pc_out, 32'h4);
    chk("rst2_valid", 32'(ifid_valid), 0);
    chk("rst2_cnt", fetch_count, 0);
    chk("rst2_mis", 32'(misaligned), 0);
    reset = 0; stall = 0; jump = 0;
    step();
    chk("rst2_run_pc", pc_out, 32'h8);
    chk("rst2_run_instr", ifid_instr, 32'hA231_0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
